alu_share_arbiter: RTL

Shares one registered-result ALU (AND/OR/ADD/SUB/MULT/SLT, 3-bit opcode, result registered on the clock edge after operands are applied) between two requesters. Each requester has a valid/ready command port and a valid/ready response port. Arbitration is round-robin, with one operation in flight at a time. The block sits between the ALU and its clients (e.g. datapath and a multi-cycle helper unit) and owns the ALU operand/opcode inputs.

---
 rtl/alu_share_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one registered-result ALU between two requesters.
// Round-robin grant, one operation in flight, 4-cycle IDLE/EXEC/CAPT/RESP flow.
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   reqN_valid/ready    command handshake, operands reqN_a/reqN_b, opcode reqN_op
//   respN_valid/ready   response handshake, respN_result/respN_zero hold last capture
//   alu_a/alu_b/alu_op  registered operands/opcode driven to the ALU
//   alu_result/alu_zero ALU registered result and its zero flag
//   busy                high whenever the FSM is not idle
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_result,
  output logic             resp0_zero,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_result,
  output logic             resp1_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StCapt = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             last_grant_q;  // requester granted most recently
  logic             owner_q;       // requester owning the in-flight operation
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic [2:0]       alu_op_q;
  logic [WIDTH-1:0] resp0_result_q, resp1_result_q;
  logic             resp0_zero_q, resp1_zero_q;

  logic grant0, grant1, is_idle, hs, hs_sel, owner_resp_ready;

  always_comb begin
    // req1 wins if alone, or on contention when req0 was served last
    grant1           = req1_valid && (!req0_valid || !last_grant_q);
    grant0           = req0_valid && !grant1;
    is_idle          = (state_q == StIdle);
    req0_ready       = is_idle && grant0;
    req1_ready       = is_idle && grant1;
    hs               = req0_ready || req1_ready;
    hs_sel           = req1_ready;
    // A ready from the non-owner is deliberately ignored
    owner_resp_ready = owner_q ? resp1_ready : resp0_ready;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (hs) state_d = StExec;
      StExec:  state_d = StCapt;
      StCapt:  state_d = StResp;
      StResp:  if (owner_resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      last_grant_q   <= 1'b1;
      owner_q        <= 1'b0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= 3'b000;
      resp0_result_q <= '0;
      resp1_result_q <= '0;
      resp0_zero_q   <= 1'b0;
      resp1_zero_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        alu_a_q      <= hs_sel ? req1_a  : req0_a;
        alu_b_q      <= hs_sel ? req1_b  : req0_b;
        alu_op_q     <= hs_sel ? req1_op : req0_op;
        owner_q      <= hs_sel;
        last_grant_q <= hs_sel;
      end
      // ALU result became valid at the end of EXEC
      if (state_q == StCapt) begin
        if (owner_q) begin
          resp1_result_q <= alu_result;
          resp1_zero_q   <= alu_zero;
        end else begin
          resp0_result_q <= alu_result;
          resp0_zero_q   <= alu_zero;
        end
      end
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign resp0_valid  = (state_q == StResp) && !owner_q;
  assign resp1_valid  = (state_q == StResp) && owner_q;
  assign resp0_result = resp0_result_q;
  assign resp1_result = resp1_result_q;
  assign resp0_zero   = resp0_zero_q;
  assign resp1_zero   = resp1_zero_q;
  assign busy         = !is_idle;

endmodule
